// File: rtl/uart_rx_with_fifo.sv
// 8N1 UART receiver feeding a synchronous byte FIFO with a registered read port.
// Define UART_RX_PARITY_EN to build an 8E1 receiver with a parity check.
module uart_rx_with_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 9
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               rx_en,
  input  logic               rx_serial_data,
  input  logic               rd_en,
  output logic [7:0]         dout,
  output logic               empty,
  output logic               almost_empty,
  output logic               full,
  output logic [FIFO_AW:0]   data_count,
  output logic               frame_err,
  output logic               overflow,
  output logic               parity_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]      BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // ---- stage p0: line synchroniser
  logic rx_meta, rxs;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_serial_data;
      rxs     <= rx_meta;
    end
  end

  // ---- stage p0 -> p1: frame decoder
  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg;
  logic          shift_en, par_en, par_bad;
  logic          push_nxt, ferr_nxt, perr_nxt;
  logic          push_vld_p1;
  logic [7:0]    push_data_p1;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ^{shreg, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    push_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && !rxs) begin
          state_nxt = START;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_cnt == BAUD_HALF) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt = '0;
          shift_en = 1'b1;
          bit_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          par_en    = 1'b1;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          push_nxt  = rxs && !par_bad;
          ferr_nxt  = !rxs;
          perr_nxt  = par_bad;
          state_nxt = rxs ? IDLE : WAIT_IDLE;
        end else begin
          baud_nxt = baud_cnt + BAUD_ONE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must go high before another start is accepted.
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      push_vld_p1 <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_idx     <= bit_nxt;
      push_vld_p1 <= push_nxt;
      frame_err   <= ferr_nxt;
      parity_err  <= perr_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (shift_en) shreg <= {rxs, shreg[7:1]};
    if (push_nxt) push_data_p1 <= shreg;
`ifdef UART_RX_PARITY_EN
    if (par_en) par_bit <= rxs;
`endif
  end

  // ---- stage p1 -> p2: FIFO write, read and status
  logic [7:0]         mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   cnt_nxt;
  logic               do_wr, do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = push_vld_p1 && !full;

  always_comb begin
    cnt_nxt = data_count;
    if (do_wr && !do_rd)      cnt_nxt = data_count + CNT_ONE;
    else if (!do_wr && do_rd) cnt_nxt = data_count - CNT_ONE;
  end

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr] <= push_data_p1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      overflow     <= 1'b0;
      dout         <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr];
      end
      data_count   <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      almost_empty <= (cnt_nxt <= CNT_ONE);
      full         <= (cnt_nxt == CNT_FULL);
      overflow     <= push_vld_p1 && full;
    end
  end

endmodule

// File: tb/tb_uart_rx_with_fifo.sv
// Directed bench for uart_rx_with_fifo at CLKS_PER_BIT=16, FIFO_AW=2.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity path.
module tb_uart_rx_with_fifo;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b0;
  logic          rx_serial_data = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    dout;
  logic          empty, almost_empty, full;
  logic [AW:0]   data_count;
  logic          frame_err, overflow, parity_err;

  int n_chk = 0;
  int n_pass = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int perr_cnt = 0;
  int ferr0, ovf0, perr0;

  uart_rx_with_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk_in(clk_in), .rst(rst), .rx_en(rx_en), .rx_serial_data(rx_serial_data),
    .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
    .full(full), .data_count(data_count), .frame_err(frame_err),
    .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_err)  ferr_cnt++;
    if (overflow)   ovf_cnt++;
    if (parity_err) perr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_bit(input logic v);
    rx_serial_data = v;
    idle(CPB);
  endtask

  // Parity bit is only placed on the line in 8E1 builds.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_v);
`else
    if (par_v === 1'bx) rx_serial_data = 1'b1;
`endif
    drive_bit(stop_v);
  endtask

  task automatic wait_push(input string tag, input int max_cyc);
    int k = 0;
    while (empty && k < max_cyc) begin
      @(negedge clk_in);
      k++;
    end
    chk(tag, {31'd0, empty}, 32'd0);
  endtask

  task automatic read_one;
    rd_en = 1'b1;
    @(negedge clk_in);
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_dout", {24'd0, dout}, 32'h00);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {29'd0, data_count}, 32'd0);
    chk("rst_pulses", {29'd0, frame_err, overflow, parity_err}, 32'd0);
    rst = 1'b0;
    rx_en = 1'b1;
    idle(5);

    // Single frame 0xA5
    send_byte(8'hA5, 1'b1, ^8'hA5);
    wait_push("a5_push", 40);
    chk("a5_count", {29'd0, data_count}, 32'd1);
    chk("a5_aempty", {31'd0, almost_empty}, 32'd1);
    read_one();
    chk("a5_dout", {24'd0, dout}, 32'hA5);
    chk("a5_empty", {31'd0, empty}, 32'd1);
    chk("a5_count0", {29'd0, data_count}, 32'd0);

    // Five back-to-back frames into a 4-deep FIFO
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, ^8'(i));
    idle(10);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_count", {29'd0, data_count}, 32'd4);
    chk("ovf_pulses", ovf_cnt - ovf0, 32'd1);
    chk("ovf_aempty", {31'd0, almost_empty}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      read_one();
      chk("ovf_rd", {24'd0, dout}, i);
    end
    chk("ovf_drained", {31'd0, empty}, 32'd1);
    chk("ovf_notfull", {31'd0, full}, 32'd0);

    // Bad stop bit, then a break held low
    ferr0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, ^8'h3C);
    idle(100);
    chk("fe_pulses", ferr_cnt - ferr0, 32'd1);
    chk("fe_nopush", {29'd0, data_count}, 32'd0);
    rx_serial_data = 1'b1;
    idle(20);
    send_byte(8'h7E, 1'b1, ^8'h7E);
    wait_push("fe_7e_push", 40);
    read_one();
    chk("fe_7e_dout", {24'd0, dout}, 32'h7E);
    chk("fe_pulses2", ferr_cnt - ferr0, 32'd1);

    // Short glitch on idle line, then read from empty
    ferr0 = ferr_cnt;
    perr0 = perr_cnt;
    rx_serial_data = 1'b0;
    idle(5);
    rx_serial_data = 1'b1;
    idle(200);
    chk("gl_empty", {31'd0, empty}, 32'd1);
    chk("gl_errs", (ferr_cnt - ferr0) + (perr_cnt - perr0), 32'd0);
    read_one();
    idle(2);
    chk("gl_dout_hold", {24'd0, dout}, 32'h7E);
    chk("gl_count", {29'd0, data_count}, 32'd0);

    // Reset mid-frame with two bytes buffered
    send_byte(8'h11, 1'b1, ^8'h11);
    send_byte(8'h22, 1'b1, ^8'h22);
    idle(5);
    chk("mr_count2", {29'd0, data_count}, 32'd2);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst = 1'b1;
    rx_serial_data = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    chk("mr_empty", {31'd0, empty}, 32'd1);
    chk("mr_count", {29'd0, data_count}, 32'd0);
    chk("mr_dout", {24'd0, dout}, 32'h00);
    idle(200);
    chk("mr_quiet", {29'd0, data_count}, 32'd0);
    send_byte(8'hC3, 1'b1, ^8'hC3);
    wait_push("mr_c3_push", 40);
    chk("mr_c3_count", {29'd0, data_count}, 32'd1);
    read_one();
    chk("mr_c3_dout", {24'd0, dout}, 32'hC3);

`ifdef UART_RX_PARITY_EN
    // Wrong and then correct even parity on 0x0F
    perr0 = perr_cnt;
    send_byte(8'h0F, 1'b1, 1'b1);
    idle(10);
    chk("par_pulse", perr_cnt - perr0, 32'd1);
    chk("par_nopush", {29'd0, data_count}, 32'd0);
    send_byte(8'h0F, 1'b1, 1'b0);
    wait_push("par_ok_push", 40);
    read_one();
    chk("par_ok_dout", {24'd0, dout}, 32'h0F);
    chk("par_pulse2", perr_cnt - perr0, 32'd1);
`else
    chk("par_tied", perr_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
